// File: rtl/cell_draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cell_draw_arbiter_if
// Description : Bundle of the requester-side and VGA-side signals of
//               cell_draw_arbiter. Three requesters are packed bit-wise:
//               req[i], cell_x[3i+2:3i], cell_y[3i+2:3i], sel[2i+1:2i].
// Revision    : 1.0 - initial release
// ============================================================================
interface cell_draw_arbiter_if;
    logic [2:0] req;
    logic [8:0] cell_x;
    logic [8:0] cell_y;
    logic [5:0] sel;
    logic [2:0] grant;
    logic [2:0] ack;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    // Requesters plus the pixel sink (game logic / vga_adapter side)
    modport master (
        output req, cell_x, cell_y, sel,
        input  grant, ack, busy, x, y, colour, plot
    );

    // The arbiter itself
    modport slave (
        input  req, cell_x, cell_y, sel,
        output grant, ack, busy, x, y, colour, plot
    );
endinterface
`default_nettype wire

// File: rtl/cell_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cell_draw_arbiter
// Description : Shares the single VGA pixel-write port between three cell
//               drawing requesters. Each grant rasterises one
//               CELL_SIZE x CELL_SIZE cell, one pixel per cycle, px fastest.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration; otherwise fixed priority port 0 > 1 > 2.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_draw_arbiter #(
    parameter int CELL_SIZE = 14,
    parameter int X_ORIGIN  = 24,
    parameter int Y_ORIGIN  = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    cell_draw_arbiter_if.slave   bus
);

    localparam logic [7:0] C_SIZE = 8'(CELL_SIZE);
    localparam logic [7:0] C_LAST = 8'(CELL_SIZE - 1);
    localparam logic [7:0] C_X0   = 8'(X_ORIGIN);
    localparam logic [7:0] C_Y0   = 8'(Y_ORIGIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q,  state_d;
    logic [2:0] grant_q,  grant_d;
    logic [2:0] ack_q,    ack_d;
    logic [1:0] sel_q,    sel_d;
    logic [7:0] base_x_q, base_x_d;
    logic [7:0] base_y_q, base_y_d;
    logic [7:0] px_q,     px_d;
    logic [7:0] py_q,     py_d;
    logic [7:0] x_q,      x_d;
    logic [6:0] y_q,      y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q,   plot_d;

    logic [2:0] w_winner;
    logic [1:0] w_gidx;
    logic [2:0] w_cell_x;
    logic [2:0] w_cell_y;
    logic [1:0] w_sel;
    logic [7:0] w_base_x;
    logic [7:0] w_base_y;
    logic       w_px_last;
    logic       w_py_last;
    logic [7:0] w_npx;
    logic [7:0] w_npy;

    // Fill colour for each draw kind
    function automatic logic [2:0] pix_colour(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b010;
            2'd1:    return 3'b000;
            2'd2:    return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    // Cursor outlines write only the border ring; every other kind fills
    function automatic logic pix_plot(input logic [1:0] s,
                                      input logic [7:0] px,
                                      input logic [7:0] py);
        return (s != 2'd3) || (px == 8'd0) || (py == 8'd0) ||
               (px == C_LAST) || (py == C_LAST);
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;

    // Rotating priority: scan from the pointer, lowest offset wins
    always_comb begin
        w_winner = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= 3) idx = idx - 3;
            if (bus.req[idx]) w_winner = 3'b001 << idx;
        end
    end

    // Pointer moves just past the served port when its draw completes
    always_comb begin
        rr_d = rr_q;
        if (state_q == S_DONE) rr_d = (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
    end

    // Round-robin pointer register
    always_ff @(posedge clock) begin
        if (resetn) rr_q <= 2'd0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed priority: port 0 beats port 1 beats port 2
    always_comb begin
        w_winner = 3'b000;
        if      (bus.req[0]) w_winner = 3'b001;
        else if (bus.req[1]) w_winner = 3'b010;
        else if (bus.req[2]) w_winner = 3'b100;
    end
`endif

    // Decode the one-hot grant and select the granted port's fields
    always_comb begin
        w_gidx = 2'd0;
        if (grant_q[1]) w_gidx = 2'd1;
        if (grant_q[2]) w_gidx = 2'd2;
        w_cell_x = bus.cell_x[3*w_gidx +: 3];
        w_cell_y = bus.cell_y[3*w_gidx +: 3];
        w_sel    = bus.sel[2*w_gidx +: 2];
        w_base_x = C_X0 + ({5'd0, w_cell_x} * C_SIZE);
        w_base_y = C_Y0 + ({5'd0, w_cell_y} * C_SIZE);
    end

    // Raster counter stepping: px wraps to 0 and bumps py at the row end
    always_comb begin
        w_px_last = (px_q == C_LAST);
        w_py_last = (py_q == C_LAST);
        w_npx     = w_px_last ? 8'd0 : px_q + 8'd1;
        w_npy     = w_px_last ? py_q + 8'd1 : py_q;
    end

    // Next-state and registered pixel output computation
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = 3'b000;
        sel_d    = sel_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        px_d     = px_q;
        py_d     = py_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    grant_d = w_winner;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Pixel (0,0) is staged here so DRAW outputs are valid
                // from its first cycle
                sel_d    = w_sel;
                base_x_d = w_base_x;
                base_y_d = w_base_y;
                px_d     = 8'd0;
                py_d     = 8'd0;
                x_d      = w_base_x;
                y_d      = w_base_y[6:0];
                colour_d = pix_colour(w_sel);
                plot_d   = pix_plot(w_sel, 8'd0, 8'd0);
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (w_px_last && w_py_last) begin
                    ack_d   = grant_q;
                    state_d = S_DONE;
                end else begin
                    px_d   = w_npx;
                    py_d   = w_npy;
                    x_d    = base_x_q + w_npx;
                    y_d    = 7'(base_y_q + w_npy);
                    plot_d = pix_plot(sel_q, w_npx, w_npy);
                end
            end
            S_DONE: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any draw immediately
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            grant_q  <= 3'b000;
            ack_q    <= 3'b000;
            sel_q    <= 2'd0;
            base_x_q <= 8'd0;
            base_y_q <= 8'd0;
            px_q     <= 8'd0;
            py_q     <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            sel_q    <= sel_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = ack_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_draw_arbiter
// Description : Self-checking bench for cell_draw_arbiter. Directed scenarios
//               followed by randomised request batches, all compared with a
//               cell-level reference model. Honours ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_draw_arbiter;

    localparam int C  = 14;
    localparam int X0 = 24;
    localparam int Y0 = 4;

    logic clock = 1'b0;
    logic resetn;

    cell_draw_arbiter_if bus ();

    cell_draw_arbiter #(
        .CELL_SIZE (C),
        .X_ORIGIN  (X0),
        .Y_ORIGIN  (Y0)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: what each requester asked for, and arbitration pointer
    int m_cx  [3];
    int m_cy  [3];
    int m_sel [3];
    int rr_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (rr_ptr + k) % 3;
            if (r[idx]) return idx;
        end
`else
        for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
        return -1;
    endfunction

    function automatic int kind_colour(input int s);
        case (s)
            0:       return 2;
            1:       return 0;
            2:       return 7;
            default: return 4;
        endcase
    endfunction

    task automatic set_port(input int p, input int cx, input int cy, input int s);
        m_cx[p]  = cx;
        m_cy[p]  = cy;
        m_sel[p] = s;
        bus.cell_x[3*p +: 3] = 3'(cx);
        bus.cell_y[3*p +: 3] = 3'(cy);
        bus.sel[2*p +: 2]    = 2'(s);
        bus.req[p]           = 1'b1;
    endtask

    task automatic do_reset();
        resetn  = 1'b1;
        bus.req = 3'b000;
        repeat (2) @(negedge clock);
        resetn  = 1'b0;
        rr_ptr  = 0;
    endtask

    // Entered at a negedge with the DUT idle and the request already driven.
    // Returns with the DUT idle again, one negedge after the ack cycle.
    task automatic do_draw(input int port, input logic [2:0] drop,
                           input int mutate_at, output int nplots);
        int pix_err, px, py, bx, by, ecol;
        logic eplot;
        logic [2:0] oh;
        oh = 3'(1 << port);
        bx = X0 + m_cx[port] * C;
        by = Y0 + m_cy[port] * C;
        ecol = kind_colour(m_sel[port]);
        @(negedge clock);
        chk("grant_load", 32'(bus.grant), 32'(oh));
        chk("busy_load",  32'(bus.busy),  32'd1);
        chk("plot_load",  32'(bus.plot),  32'd0);
        pix_err = 0;
        nplots  = 0;
        for (int k = 0; k < C*C; k++) begin
            @(negedge clock);
            px = k % C;
            py = k / C;
            eplot = (m_sel[port] != 3) || px == 0 || py == 0 || px == C-1 || py == C-1;
            if (bus.plot !== eplot) pix_err++;
            if (bus.plot === 1'b1) begin
                nplots++;
                if (bus.x !== 8'(bx + px) || bus.y !== 7'(by + py) ||
                    bus.colour !== 3'(ecol)) pix_err++;
            end
            if (bus.ack !== 3'b000 || bus.busy !== 1'b1 || bus.grant !== oh) pix_err++;
            if (k == mutate_at) begin
                bus.cell_x[3*port +: 3] = ~bus.cell_x[3*port +: 3];
                bus.cell_y[3*port +: 3] = ~bus.cell_y[3*port +: 3];
                bus.sel[2*port +: 2]    = bus.sel[2*port +: 2] + 2'd1;
            end
        end
        chk("pixel_errors", 32'(pix_err), 32'd0);
        @(negedge clock);
        chk("ack_done",   32'(bus.ack),   32'(oh));
        chk("grant_done", 32'(bus.grant), 32'(oh));
        chk("plot_done",  32'(bus.plot),  32'd0);
        chk("busy_done",  32'(bus.busy),  32'd1);
        rr_ptr  = (port + 1) % 3;
        bus.req = bus.req & ~drop;
        @(negedge clock);
        chk("ack_idle",   32'(bus.ack),   32'd0);
        chk("grant_idle", 32'(bus.grant), 32'd0);
        chk("busy_idle",  32'(bus.busy),  32'd0);
        chk("plot_idle",  32'(bus.plot),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p, mask;
        bus.req    = 3'b000;
        bus.cell_x = '0;
        bus.cell_y = '0;
        bus.sel    = '0;
        resetn     = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b0;

        // Reset state
        chk("rst_grant",  32'(bus.grant),  32'd0);
        chk("rst_ack",    32'(bus.ack),    32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_x",      32'(bus.x),      32'd0);
        chk("rst_y",      32'(bus.y),      32'd0);
        chk("rst_colour", 32'(bus.colour), 32'd0);
        chk("rst_plot",   32'(bus.plot),   32'd0);

        // Port 0, cell (0,0), black disk: full 196-pixel fill
        set_port(0, 0, 0, 1);
        do_draw(pick(bus.req), 3'b001, -1, n);
        chk("t1_plots", 32'(n), 32'd196);

        // Port 1, cell (7,7), cursor outline: perimeter only
        set_port(1, 7, 7, 3);
        do_draw(pick(bus.req), 3'b010, -1, n);
        chk("t2_plots", 32'(n), 32'd52);

        // All three requesting continuously
        do_reset();
        set_port(0, 1, 2, 0);
        set_port(1, 2, 3, 1);
        set_port(2, 4, 5, 2);
        for (int i = 0; i < 4; i++) begin
            do_draw(pick(bus.req), (i == 3) ? 3'b111 : 3'b000, -1, n);
        end

        // Inputs changed mid-draw have no effect
        set_port(2, 3, 5, 2);
        do_draw(pick(bus.req), 3'b100, 50, n);
        chk("t4_plots", 32'(n), 32'd196);

        // Reset in the middle of a draw
        set_port(1, 6, 1, 0);
        @(negedge clock);
        chk("t5_grant", 32'(bus.grant), 32'b010);
        repeat (100) @(negedge clock);
        chk("t5_plot_mid", 32'(bus.plot), 32'd1);
        resetn  = 1'b1;
        bus.req = 3'b000;
        @(negedge clock);
        chk("t5_plot",  32'(bus.plot),  32'd0);
        chk("t5_busy",  32'(bus.busy),  32'd0);
        chk("t5_ack",   32'(bus.ack),   32'd0);
        chk("t5_grant0", 32'(bus.grant), 32'd0);
        resetn = 1'b0;
        rr_ptr = 0;
        @(negedge clock);
        chk("t5_ack_after", 32'(bus.ack), 32'd0);
        set_port(1, 5, 0, 3);
        do_draw(pick(bus.req), 3'b010, -1, n);

        // Random batches of simultaneous requests
        for (int b = 0; b < 5; b++) begin
            mask = int'($urandom_range(1, 7));
            for (int q = 0; q < 3; q++) begin
                if (mask[q]) set_port(q, int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 3)));
            end
            while (bus.req != 3'b000) begin
                p = pick(bus.req);
                do_draw(p, 3'(1 << p),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 195)) : -1, n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
